// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  // A port parameter is named PARITY, so the state literals carry a prefix.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus a falling-edge detector.
// All flops reset to 1 so a line held in reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rxs  = s2;
  assign fall = prev & ~s2;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each bit centre (+1 clock latency).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int BIT_W = clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = CLKS_PER_BIT / 2;
`else
  localparam int START_PT = CLKS_PER_BIT / 2 - 1;
`endif
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  rx_state_e state, state_n;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_r, frm_err_r;
  logic                 rxs, fall, bit_val;
  logic                 start_tick, tick, last_data, last_stop;
  logic                 par_x, par_calc;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rxs  (rxs),
    .fall (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decision is taken one clock after the centre, voting centre-1, centre, centre+1.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rxs};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign bit_val = rxs;
`endif

  assign start_tick = (clk_cnt == START_CNT);
  assign tick       = (clk_cnt == LAST_CNT);
  assign last_data  = (bit_cnt == DATA_LAST);
  assign last_stop  = (bit_cnt == STOP_LAST);
  assign par_x      = (^shreg) ^ bit_val;
  assign par_calc   = (PARITY == PAR_ODD) ? ~par_x : par_x;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (fall) state_n = ST_START;
      ST_START:  if (start_tick) state_n = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && last_data)
                   state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_n = ST_STOP;
      ST_STOP:   if (tick && last_stop) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      dout       <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt   <= '0;
          bit_cnt   <= '0;
          par_err_r <= 1'b0;
          frm_err_r <= 1'b0;
        end
        ST_START: clk_cnt <= start_tick ? '0 : clk_cnt + CNT_ONE;
        default: begin
          clk_cnt <= tick ? '0 : clk_cnt + CNT_ONE;
          if (tick) begin
            case (state)
              ST_DATA: begin
                for (int i = 0; i < DATA_BITS; i++)
                  if (bit_cnt == BIT_W'(i)) shreg[i] <= bit_val;
                bit_cnt <= last_data ? '0 : bit_cnt + BIT_ONE;
              end
              ST_PARITY: par_err_r <= par_calc;
              ST_STOP: begin
                if (!bit_val) frm_err_r <= 1'b1;
                bit_cnt <= bit_cnt + BIT_ONE;
                // Frame is published on the final stop sample so IDLE is
                // back well before the stop period ends.
                if (last_stop) begin
                  rx_done    <= 1'b1;
                  dout       <= shreg;
                  frame_err  <= frm_err_r | ~bit_val;
                  parity_err <= par_err_r;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and an 8E2 instance, each checked
// against a frame-level model (expected completion cycle, word and flags).
module tb_uart_rx_os;

  localparam int C = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic done_a, fe_a, pe_a, busy_a;
  logic done_b, fe_b, pe_b, busy_b;

  uart_rx_os #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .dout(dout_a), .rx_done(done_a),
    .frame_err(fe_a), .parity_err(pe_a), .busy(busy_a)
  );

  uart_rx_os #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .dout(dout_b), .rx_done(done_b),
    .frame_err(fe_b), .parity_err(pe_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t hold_a, hold_b;
  int   last_done[2];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Clocks from the rxs falling edge to rx_done.
  function automatic int frame_len(input int npar, input int nstop);
    return C / 2 + C * (8 + npar + nstop) + 1 + MAJ;
  endfunction

  task automatic set_rx(input int u, input logic v);
    if (u == 0) rx_a = v;
    else        rx_b = v;
  endtask

  // Called at posedge+1. Each bit is held C clocks; a spike inverts the
  // line for one clock at the bit centre. abort_at >= 0 stops halfway into that bit.
  task automatic send_frame(input int u, input logic [7:0] d, input int par_mode,
                            input logic pbit, input logic [1:0] stops, input int nstop,
                            input int gap, input bit spike, input int abort_at);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_mode != 0) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    if (abort_at < 0) begin
      // rx reaches rxs two clocks after it is driven.
      e.t  = cyc + 2 + frame_len((par_mode != 0) ? 1 : 0, nstop);
      e.d  = d;
      e.fe = (nstop == 2) ? !(stops[0] & stops[1]) : !stops[0];
      if (par_mode == 0)      e.pe = 1'b0;
      else if (par_mode == 1) e.pe = (^d) ^ pbit;
      else                    e.pe = !((^d) ^ pbit);
      if (u == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    for (int k = 0; k < bits.size(); k++) begin
      if (k == abort_at) begin
        set_rx(u, bits[k]);
        repeat (C / 2) @(posedge clk);
        #1;
        return;
      end
      for (int j = 0; j < C; j++) begin
        set_rx(u, (spike && j == C / 2) ? ~bits[k] : bits[k]);
        @(posedge clk);
        #1;
      end
    end
    set_rx(u, 1'b1);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic check_unit(input int u, input logic done, input logic [7:0] d,
                            input logic fe, input logic pe);
    exp_t e, h;
    int have;
    have = (u == 0) ? qa.size() : qb.size();
    if (have > 0) begin
      if (u == 0) e = qa[0];
      else        e = qb[0];
    end
    h = (u == 0) ? hold_a : hold_b;
    if (done) begin
      chk($sformatf("u%0d rx_done expected", u), (have > 0) ? 1 : 0, 1);
      if (have > 0) begin
        if (u == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk($sformatf("u%0d done cycle", u), cyc, e.t);
        chk($sformatf("u%0d dout", u), d, e.d);
        chk($sformatf("u%0d frame_err", u), fe, e.fe);
        chk($sformatf("u%0d parity_err", u), pe, e.pe);
        if (u == 0) hold_a = e;
        else        hold_b = e;
        last_done[u] = cyc;
      end
    end else begin
      if (have > 0 && cyc > e.t) begin
        chk($sformatf("u%0d rx_done missing", u), cyc, e.t);
        if (u == 0) e = qa.pop_front();
        else        e = qb.pop_front();
      end
      chk($sformatf("u%0d dout hold", u), d, h.d);
      chk($sformatf("u%0d frame_err hold", u), fe, h.fe);
      chk($sformatf("u%0d parity_err hold", u), pe, h.pe);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_unit(0, done_a, dout_a, fe_a, pe_a);
      check_unit(1, done_b, dout_b, fe_b, pe_b);
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, " dout_a"}, dout_a, 0);
    chk({nm, " done_a"}, done_a, 0);
    chk({nm, " fe_a"}, fe_a, 0);
    chk({nm, " pe_a"}, pe_a, 0);
    chk({nm, " busy_a"}, busy_a, 0);
    chk({nm, " dout_b"}, dout_b, 0);
    chk({nm, " done_b"}, done_b, 0);
    chk({nm, " fe_b"}, fe_b, 0);
    chk({nm, " pe_b"}, pe_b, 0);
    chk({nm, " busy_b"}, busy_b, 0);
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    hold_a = '{t: 0, d: 8'h00, fe: 1'b0, pe: 1'b0};
    hold_b = '{t: 0, d: 8'h00, fe: 1'b0, pe: 1'b0};
  endtask

  initial begin
    int t0, ta;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single 8N1 frame: latency pinned to 153 clocks from the rxs edge.
    t0 = cyc;
    send_frame(0, 8'hA5, 0, 1'b0, 2'b11, 1, 10, 1'b0, -1);
    chk("A5 latency", last_done[0] - (t0 + 2), 153 + MAJ);
    chk("A5 dout", dout_a, 8'hA5);
    chk("A5 flags", {fe_a, pe_a}, 0);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h00, 0, 1'b0, 2'b11, 1, 0, 1'b0, -1);
    ta = last_done[0];
    chk("b2b first dout", dout_a, 8'h00);
    send_frame(0, 8'hFF, 0, 1'b0, 2'b11, 1, 10, 1'b0, -1);
    chk("b2b spacing", last_done[0] - ta, 160);
    chk("b2b second dout", dout_a, 8'hFF);

    // Three-clock glitch: start check rejects it.
    t0 = cyc;
    rx_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch busy high", busy_a, 1);
    repeat (t0 + 12 - cyc) @(posedge clk);
    #1;
    chk("glitch busy cleared", busy_a, 0);
    repeat (10) @(posedge clk);
    #1;

    // Even parity, 0x03 with wrong parity bit.
    send_frame(1, 8'h03, 1, 1'b1, 2'b11, 2, 10, 1'b0, -1);
    chk("par dout", dout_b, 8'h03);
    chk("par parity_err", pe_b, 1);
    chk("par frame_err", fe_b, 0);

    // Second stop bit low, line then stuck low: no further frames.
    send_frame(1, 8'h81, 1, 1'b0, 2'b01, 2, 0, 1'b0, -1);
    rx_b = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    chk("stuck frame_err", fe_b, 1);
    chk("stuck busy", busy_b, 0);
    rx_b = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_frame(1, 8'h5A, 1, 1'b0, 2'b11, 2, 10, 1'b0, -1);
    chk("recover dout", dout_b, 8'h5A);
    chk("recover flags", {fe_b, pe_b}, 0);

    // Randomized traffic on both receivers.
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          logic [7:0] d;
          logic bad;
          d   = 8'($urandom);
          bad = ($urandom_range(0, 7) == 0);
          send_frame(0, d, 0, 1'b0, bad ? 2'b00 : 2'b11, 1,
                     bad ? $urandom_range(2, 12) : $urandom_range(0, 3), 1'b0, -1);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          logic [7:0] d;
          logic [1:0] st;
          logic pb;
          d     = 8'($urandom);
          pb    = (^d) ^ ($urandom_range(0, 3) == 0);
          st[0] = ($urandom_range(0, 7) != 0);
          st[1] = ($urandom_range(0, 7) != 0);
          send_frame(1, d, 1, pb, st, 2,
                     st[1] ? $urandom_range(0, 3) : $urandom_range(2, 12), 1'b0, -1);
        end
      end
    join

`ifdef UART_RX_MAJORITY_EN
    // One-clock spikes at every bit centre are outvoted.
    send_frame(0, 8'hC3, 0, 1'b0, 2'b11, 1, 10, 1'b1, -1);
    chk("spike dout", dout_a, 8'hC3);
    chk("spike flags", {fe_a, pe_a}, 0);
`endif

    // Reset in the middle of data bit 4, then a clean frame.
    send_frame(0, 8'h77, 0, 1'b0, 2'b11, 1, 0, 1'b0, 5);
    chk("pre-reset busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check_zero("mid-frame reset");
    clear_model();
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send_frame(0, 8'h3C, 0, 1'b0, 2'b11, 1, 10, 1'b0, -1);
    chk("post-reset dout", dout_a, 8'h3C);
    chk("post-reset flags", {fe_a, pe_a}, 0);

    repeat (50) @(posedge clk);
    #1;
    chk("model queue drained", qa.size() + qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
